// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if
//   Bundles the CPU port, the VGA read port and the memory-side bus of the
//   data-memory arbiter.
//   slave  : arbiter view (takes requests and mem_rdata, drives acks,
//            read responses and the memory address/control).
//   master : environment view (requesters plus memory model).
//   CPU    : cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_ack/cpu_rvalid/cpu_rdata
//   VGA    : vga_req/vga_addr -> vga_ack/vga_rvalid/vga_rdata
//   Memory : mem_addr/mem_we/mem_wdata -> mem_rdata (1-cycle read latency)
interface dmem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_ack;
   logic          cpu_rvalid;
   logic [DW-1:0] cpu_rdata;

   logic          vga_req;
   logic [AW-1:0] vga_addr;
   logic          vga_ack;
   logic          vga_rvalid;
   logic [DW-1:0] vga_rdata;

   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
      output cpu_ack, cpu_rvalid, cpu_rdata, vga_ack, vga_rvalid, vga_rdata,
             mem_addr, mem_we, mem_wdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
      input  cpu_ack, cpu_rvalid, cpu_rdata, vga_ack, vga_rvalid, vga_rdata,
             mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares a single-port data memory between the CPU (read/write) and the
//   VGA pixel fetcher (read-only). VGA has fixed priority because of its
//   scan-out deadline; a saturating wait counter forces a CPU slot after
//   MAX_WAIT consecutive stalled cycles.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-low
//   bus    : dmem_port_arbiter_if.slave (CPU, VGA and memory signals)
//   Optional (macro ARB_STATS_EN): stat_clr input and the grant/stall
//   counters stat_cpu_grants, stat_vga_grants, stat_forced, stat_cpu_stall.
module dmem_port_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic                 clk,
   input  logic                 reset,
`ifdef ARB_STATS_EN
   input  logic                 stat_clr,
   output logic [31:0]          stat_cpu_grants,
   output logic [31:0]          stat_vga_grants,
   output logic [15:0]          stat_forced,
   output logic [31:0]          stat_cpu_stall,
`endif
   dmem_port_arbiter_if.slave   bus
);

   localparam int WW = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VGA} owner_t;

   logic [WW-1:0] wait_cnt;
   owner_t        rd_owner;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] cpu_hold, vga_hold;

   logic          force_cpu, cpu_gnt, vga_gnt;
   logic [AW-1:0] mem_addr_c;
   logic [DW-1:0] mem_wdata_c;
   logic          mem_we_c;
   logic          cpu_rvalid_c, vga_rvalid_c;

   // Grant: starved CPU first, then VGA, then CPU. Reset masks every grant.
   always_comb begin
      force_cpu = bus.cpu_req && (wait_cnt == WW'(MAX_WAIT));
      cpu_gnt   = 1'b0;
      vga_gnt   = 1'b0;
      if (reset) begin
         if (force_cpu)        cpu_gnt = 1'b1;
         else if (bus.vga_req) vga_gnt = 1'b1;
         else if (bus.cpu_req) cpu_gnt = 1'b1;
      end
   end

   // Idle cycles keep the last issued address on the bus to avoid toggling.
   always_comb begin
      mem_addr_c  = addr_q;
      mem_we_c    = 1'b0;
      mem_wdata_c = '0;
      if (cpu_gnt) begin
         mem_addr_c  = bus.cpu_addr;
         mem_we_c    = bus.cpu_we;
         mem_wdata_c = bus.cpu_wdata;
      end else if (vga_gnt) begin
         mem_addr_c  = bus.vga_addr;
      end
   end

   // Responses come from the owner recorded last cycle; reset also masks them
   // so a read in flight when reset asserts never returns.
   assign cpu_rvalid_c   = reset && (rd_owner == OWN_CPU);
   assign vga_rvalid_c   = reset && (rd_owner == OWN_VGA);

   assign bus.cpu_ack    = cpu_gnt;
   assign bus.vga_ack    = vga_gnt;
   assign bus.mem_addr   = mem_addr_c;
   assign bus.mem_we     = mem_we_c;
   assign bus.mem_wdata  = mem_wdata_c;
   assign bus.cpu_rvalid = cpu_rvalid_c;
   assign bus.vga_rvalid = vga_rvalid_c;
   assign bus.cpu_rdata  = cpu_rvalid_c ? bus.mem_rdata : cpu_hold;
   assign bus.vga_rdata  = vga_rvalid_c ? bus.mem_rdata : vga_hold;

   always_ff @(posedge clk) begin
      if (!reset) begin
         wait_cnt <= '0;
         rd_owner <= OWN_NONE;
         addr_q   <= '0;
         cpu_hold <= '0;
         vga_hold <= '0;
      end else begin
         // A dropped request cancels, so starvation history restarts.
         if (cpu_gnt || !bus.cpu_req)
            wait_cnt <= '0;
         else if (wait_cnt != WW'(MAX_WAIT))
            wait_cnt <= wait_cnt + 1'b1;

         if (cpu_gnt && !bus.cpu_we) rd_owner <= OWN_CPU;
         else if (vga_gnt)           rd_owner <= OWN_VGA;
         else                        rd_owner <= OWN_NONE;

         if (cpu_gnt || vga_gnt) addr_q <= mem_addr_c;
         if (cpu_rvalid_c)       cpu_hold <= bus.mem_rdata;
         if (vga_rvalid_c)       vga_hold <= bus.mem_rdata;
      end
   end

`ifdef ARB_STATS_EN
   // Free-running event counters; clear takes precedence over counting.
   always_ff @(posedge clk) begin
      if (!reset || stat_clr) begin
         stat_cpu_grants <= '0;
         stat_vga_grants <= '0;
         stat_forced     <= '0;
         stat_cpu_stall  <= '0;
      end else begin
         stat_cpu_grants <= stat_cpu_grants + 32'(cpu_gnt);
         stat_vga_grants <= stat_vga_grants + 32'(vga_gnt);
         stat_forced     <= stat_forced + 16'(force_cpu);
         stat_cpu_stall  <= stat_cpu_stall + 32'(bus.cpu_req && !cpu_gnt);
      end
   end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
//   Directed bench for dmem_port_arbiter (MAX_WAIT = 4). A behavioural
//   memory with one-cycle read latency sits on the memory bus; expected read
//   data is queued per requester at each ack and popped when rvalid is due.
//   Define ARB_STATS_EN to also exercise the statistics counters.
module tb_dmem_port_arbiter;

   logic clk;
   logic reset;
`ifdef ARB_STATS_EN
   logic        stat_clr;
   logic [31:0] stat_cpu_grants, stat_vga_grants, stat_cpu_stall;
   logic [15:0] stat_forced;
`endif

   dmem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

   dmem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
      .clk             (clk),
      .reset           (reset),
`ifdef ARB_STATS_EN
      .stat_clr        (stat_clr),
      .stat_cpu_grants (stat_cpu_grants),
      .stat_vga_grants (stat_vga_grants),
      .stat_forced     (stat_forced),
      .stat_cpu_stall  (stat_cpu_stall),
`endif
      .bus             (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem     [0:255];
   logic [31:0] exp_mem [0:255];

   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr[7:0]];
   end

   int          checks = 0;
   int          errors = 0;
   logic [31:0] cpu_q[$];
   logic [31:0] vga_q[$];
   logic        last_cpu_ack, last_vga_ack;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Checks one cycle at the falling edge, then advances past the next rising edge.
   task automatic cyc(input logic ecpu, input logic evga);
      logic [31:0] e;
      @(negedge clk);
      chk("cpu_ack", bus.cpu_ack, ecpu);
      chk("vga_ack", bus.vga_ack, evga);
      chk("mem_we", bus.mem_we, ecpu && bus.cpu_we);
      if (ecpu) chk("mem_addr_cpu", bus.mem_addr, bus.cpu_addr);
      if (evga) chk("mem_addr_vga", bus.mem_addr, bus.vga_addr);
      chk("cpu_rvalid", bus.cpu_rvalid, cpu_q.size() != 0);
      if (cpu_q.size() != 0) begin
         e = cpu_q.pop_front();
         if (bus.cpu_rvalid) chk("cpu_rdata", bus.cpu_rdata, e);
      end
      chk("vga_rvalid", bus.vga_rvalid, vga_q.size() != 0);
      if (vga_q.size() != 0) begin
         e = vga_q.pop_front();
         if (bus.vga_rvalid) chk("vga_rdata", bus.vga_rdata, e);
      end
      last_cpu_ack = bus.cpu_ack;
      last_vga_ack = bus.vga_ack;
      if (bus.cpu_ack && !bus.cpu_we) cpu_q.push_back(exp_mem[bus.cpu_addr[7:0]]);
      if (bus.vga_ack) vga_q.push_back(exp_mem[bus.vga_addr[7:0]]);
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 32'hC0DE0000 + 32'(i);
         exp_mem[i] = 32'hC0DE0000 + 32'(i);
      end
      for (int i = 0; i < 16; i++) begin
         mem[i]     = 32'hA0 + 32'(i);
         exp_mem[i] = 32'hA0 + 32'(i);
      end
      mem[16'h10]     = 32'hDEADBEEF;
      exp_mem[16'h10] = 32'hDEADBEEF;

      // Reset with both requesters asserted: nothing may be granted.
      reset = 1'b0;
`ifdef ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h44;
      bus.cpu_wdata = 32'h55; bus.vga_req = 1'b1; bus.vga_addr = 32'h66;
      @(posedge clk); #1;
      @(posedge clk); #1;
      cyc(1'b0, 1'b0);
      @(negedge clk);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
      chk("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
      chk("rst_vga_rdata", bus.vga_rdata, 32'h0);
      @(posedge clk); #1;
      bus.cpu_req = 1'b0; bus.vga_req = 1'b0; bus.cpu_we = 1'b0;
      reset = 1'b1;
      cyc(1'b0, 1'b0);

      // CPU-only read.
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10;
      cyc(1'b1, 1'b0);
      bus.cpu_req = 1'b0;
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      @(negedge clk);
      chk("cpu_rdata_hold", bus.cpu_rdata, 32'hDEADBEEF);
      chk("idle_mem_addr", bus.mem_addr, 32'h10);
      @(posedge clk); #1;

      // CPU write: bus driven in the ack cycle, no read response after.
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h20;
      bus.cpu_wdata = 32'h12345678;
      @(negedge clk);
      chk("wr_mem_wdata", bus.mem_wdata, 32'h12345678);
      @(posedge clk); #1;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
      exp_mem[8'h20] = 32'h12345678;
      cyc(1'b0, 1'b0);
      @(negedge clk);
      chk("idle_mem_addr_wr", bus.mem_addr, 32'h20);
      chk("idle_mem_wdata", bus.mem_wdata, 32'h0);
      @(posedge clk); #1;
      bus.cpu_req = 1'b1; bus.cpu_addr = 32'h20;
      cyc(1'b1, 1'b0);
      bus.cpu_req = 1'b0;
      cyc(1'b0, 1'b0);

`ifdef ARB_STATS_EN
      stat_clr = 1'b1;
      cyc(1'b0, 1'b0);
      stat_clr = 1'b0;
`endif

      // Contention: VGA streams 0..9, CPU reads 0x30 and is forced in at cycle 4.
      bus.vga_req = 1'b1; bus.vga_addr = 32'h0;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h30;
      for (int c = 0; c < 10; c++) begin
         cyc(c == 4, c != 4);
         if (last_vga_ack) bus.vga_addr = bus.vga_addr + 32'h1;
         if (last_cpu_ack) bus.cpu_req = 1'b0;
      end
      bus.vga_req = 1'b0; bus.cpu_req = 1'b0;
      cyc(1'b0, 1'b0);
`ifdef ARB_STATS_EN
      chk("stat_vga_grants", stat_vga_grants, 32'd9);
      chk("stat_cpu_grants", stat_cpu_grants, 32'd1);
      chk("stat_forced", stat_forced, 16'd1);
      chk("stat_cpu_stall", stat_cpu_stall, 32'd4);
      stat_clr = 1'b1;
      cyc(1'b0, 1'b0);
      stat_clr = 1'b0;
      chk("stat_clr_vga", stat_vga_grants, 32'd0);
      chk("stat_clr_cpu", stat_cpu_grants, 32'd0);
      chk("stat_clr_forced", stat_forced, 16'd0);
      chk("stat_clr_stall", stat_cpu_stall, 32'd0);
`endif

      // Dropping cpu_req restarts the starvation count.
      bus.vga_req = 1'b1; bus.vga_addr = 32'h40;
      bus.cpu_addr = 32'h31;
      for (int c = 0; c < 8; c++) begin
         bus.cpu_req = (c != 2);
         cyc(c == 7, c != 7);
         if (last_vga_ack) bus.vga_addr = bus.vga_addr + 32'h1;
      end
      bus.vga_req = 1'b0; bus.cpu_req = 1'b0;
      cyc(1'b0, 1'b0);

      // Back-to-back VGA reads 0,1,2.
      bus.vga_req = 1'b1;
      for (int c = 0; c < 3; c++) begin
         bus.vga_addr = 32'(c);
         cyc(1'b0, 1'b1);
      end
      bus.vga_req = 1'b0;
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      @(negedge clk);
      chk("vga_rdata_hold", bus.vga_rdata, 32'hA2);
      @(posedge clk); #1;

      // Reset while a VGA read is in flight: response is dropped.
      bus.vga_req = 1'b1; bus.vga_addr = 32'h5;
      cyc(1'b0, 1'b1);
      bus.vga_req = 1'b0;
      reset = 1'b0;
      vga_q.delete();
      cyc(1'b0, 1'b0);
      reset = 1'b1;
      cyc(1'b0, 1'b0);
      @(negedge clk);
      chk("post_rst_vga_rdata", bus.vga_rdata, 32'h0);
      @(posedge clk); #1;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10;
      cyc(1'b1, 1'b0);
      bus.cpu_req = 1'b0;
      cyc(1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
